// File: rtl/reg_file_pkg.sv
// Shared sizing defaults and types for the parametrised register file.
// Optional write-through bypass is enabled by defining REG_FILE_FORWARD_EN.
package reg_file_pkg;

    localparam int REG_FILE_DATA_W   = 16;
    localparam int REG_FILE_NUM_REGS = 32;
    localparam int REG_FILE_ADDR_W   = $clog2(REG_FILE_NUM_REGS);

    typedef logic [REG_FILE_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_FILE_DATA_W-1:0] reg_data_t;

    // Address width for a given register count, never less than one bit.
    function automatic int addr_width(input int num_regs);
        return (num_regs < 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits.
// A reserve sets a bit and a writeback clears it; reserve wins when both hit the same register.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = REG_FILE_NUM_REGS,
    parameter int ADDR_W   = addr_width(NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic [ADDR_W-1:0] i_look_a_addr,
    input  logic [ADDR_W-1:0] i_look_b_addr,
    output logic              o_busy_a,
    output logic              o_busy_b
);

    logic [NUM_REGS-1:0] r_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_set_en && (i_set_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (i_clr_en && (i_clr_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
            if (ZERO_REG != 0) begin
                r_busy[0] <= 1'b0;
            end
        end
    end

    // Lookups see the current state, so a same-cycle reserve shows up on the next read.
    assign o_busy_a = r_busy[i_look_a_addr];
    assign o_busy_b = r_busy[i_look_b_addr];

endmodule

// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with immediate mux on port A and busy scoreboard.
// Define REG_FILE_FORWARD_EN to bypass same-cycle write data onto the read ports.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = REG_FILE_DATA_W,
    parameter int NUM_REGS = REG_FILE_NUM_REGS,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = addr_width(NUM_REGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_ra_addr,
    input  logic [ADDR_W-1:0] i_rb_addr,
    input  logic [DATA_W-1:0] i_imm,
    input  logic              i_imm_sel,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wc_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rsv_en,
    input  logic [ADDR_W-1:0] i_rsv_addr,
    output logic [DATA_W-1:0] o_ra_data,
    output logic [DATA_W-1:0] o_rb_data,
    output logic              o_ra_busy,
    output logic              o_rb_busy,
    output logic              o_rd_valid
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic              w_wr_ok;
    logic              w_ra_fwd;
    logic              w_rb_fwd;
    logic              w_sb_busy_a;
    logic              w_sb_busy_b;
    logic [DATA_W-1:0] w_ra_reg;
    logic [DATA_W-1:0] w_rb_reg;
    logic [DATA_W-1:0] w_ra_next;
    logic [DATA_W-1:0] w_rb_next;
    logic              w_ra_busy_next;
    logic              w_rb_busy_next;

    reg_file_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_set_en      (i_rsv_en),
        .i_set_addr    (i_rsv_addr),
        .i_clr_en      (i_wr_en),
        .i_clr_addr    (i_wc_addr),
        .i_look_a_addr (i_ra_addr),
        .i_look_b_addr (i_rb_addr),
        .o_busy_a      (w_sb_busy_a),
        .o_busy_b      (w_sb_busy_b)
    );

    // Writes to the hardwired zero register are dropped, and so is any bypass of them.
    assign w_wr_ok = i_wr_en && !((ZERO_REG != 0) && (i_wc_addr == '0));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_wc_addr] <= i_wr_data;
        end
    end

`ifdef REG_FILE_FORWARD_EN
    assign w_ra_fwd = w_wr_ok && (i_ra_addr == i_wc_addr);
    assign w_rb_fwd = w_wr_ok && (i_rb_addr == i_wc_addr);
`else
    assign w_ra_fwd = 1'b0;
    assign w_rb_fwd = 1'b0;
`endif

    always_comb begin
        w_ra_reg = r_regs[i_ra_addr];
        w_rb_reg = r_regs[i_rb_addr];
        if ((ZERO_REG != 0) && (i_ra_addr == '0)) begin
            w_ra_reg = '0;
        end
        if ((ZERO_REG != 0) && (i_rb_addr == '0)) begin
            w_rb_reg = '0;
        end
    end

    // The immediate takes priority over any bypass on port A and is never busy.
    always_comb begin
        w_ra_next      = w_ra_reg;
        w_ra_busy_next = w_sb_busy_a;
        if (i_imm_sel) begin
            w_ra_next      = i_imm;
            w_ra_busy_next = 1'b0;
        end else if (w_ra_fwd) begin
            w_ra_next      = i_wr_data;
            w_ra_busy_next = 1'b0;
        end

        w_rb_next      = w_rb_reg;
        w_rb_busy_next = w_sb_busy_b;
        if (w_rb_fwd) begin
            w_rb_next      = i_wr_data;
            w_rb_busy_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ra_data  <= '0;
            o_rb_data  <= '0;
            o_ra_busy  <= 1'b0;
            o_rb_busy  <= 1'b0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                o_ra_data <= w_ra_next;
                o_rb_data <= w_rb_next;
                o_ra_busy <= w_ra_busy_next;
                o_rb_busy <= w_rb_busy_next;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param (default 16x32, zero register on).
// Collision expectations follow REG_FILE_FORWARD_EN when it is defined for the build.
module tb_reg_file_param;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic [15:0] imm;
    logic        imm_sel;
    logic        wr_en;
    logic [4:0]  wc_addr;
    logic [15:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [15:0] ra_data;
    logic [15:0] rb_data;
    logic        ra_busy;
    logic        rb_busy;
    logic        rd_valid;

    int tests_run;
    int tests_failed;

    reg_file_param dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rd_en    (rd_en),
        .i_ra_addr  (ra_addr),
        .i_rb_addr  (rb_addr),
        .i_imm      (imm),
        .i_imm_sel  (imm_sel),
        .i_wr_en    (wr_en),
        .i_wc_addr  (wc_addr),
        .i_wr_data  (wr_data),
        .i_rsv_en   (rsv_en),
        .i_rsv_addr (rsv_addr),
        .o_ra_data  (ra_data),
        .o_rb_data  (rb_data),
        .o_ra_busy  (ra_busy),
        .o_rb_busy  (rb_busy),
        .o_rd_valid (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; rd_en = 1'b0; ra_addr = '0; rb_addr = '0;
        imm = '0; imm_sel = 1'b0; wr_en = 1'b0; wc_addr = '0;
        wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (rd_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got %b expected 0", rd_valid);
        end
        rd_en = 1'b1; ra_addr = 5'd5; rb_addr = 5'd31;
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (ra_data !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_ra_data: got %h expected 0000", ra_data);
        end
        tests_run++;
        if (rb_data !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_rb_data: got %h expected 0000", rb_data);
        end
        tests_run++;
        if ({rd_valid, ra_busy, rb_busy} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL reset_first_read_flags: got %b expected 100", {rd_valid, ra_busy, rb_busy});
        end
        tick();
        tests_run++;
        if (rd_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL valid_drops: got %b expected 0", rd_valid);
        end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wc_addr = 5'd3; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1; ra_addr = 5'd3; rb_addr = 5'd5;
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (ra_data !== 16'hBEEF) begin
            tests_failed++;
            $display("[TB] FAIL write_read_r3: got %h expected beef", ra_data);
        end
        tests_run++;
        if (rb_data !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL untouched_r5: got %h expected 0000", rb_data);
        end
        tick();
        tests_run++;
        if (ra_data !== 16'hBEEF || rd_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hold_when_idle: got %h/%b expected beef/0", ra_data, rd_valid);
        end
        wr_en = 1'b1; wc_addr = 5'd0; wr_data = 16'h1234;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1; ra_addr = 5'd0; rb_addr = 5'd0;
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (ra_data !== 16'h0000 || rb_data !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL zero_reg: got %h/%h expected 0000/0000", ra_data, rb_data);
        end
    endtask

    task automatic test_collision();
        logic [15:0] exp_data;
`ifdef REG_FILE_FORWARD_EN
        exp_data = 16'hA5A5;
`else
        exp_data = 16'h1111;
`endif
        wr_en = 1'b1; wc_addr = 5'd7; wr_data = 16'h1111;
        tick();
        wr_data = 16'hA5A5;
        rd_en = 1'b1; ra_addr = 5'd7; rb_addr = 5'd7;
        tick();
        wr_en = 1'b0;
        tests_run++;
        if (ra_data !== exp_data) begin
            tests_failed++;
            $display("[TB] FAIL collision_ra: got %h expected %h", ra_data, exp_data);
        end
        tests_run++;
        if (rb_data !== exp_data) begin
            tests_failed++;
            $display("[TB] FAIL collision_rb: got %h expected %h", rb_data, exp_data);
        end
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (ra_data !== 16'hA5A5 || rb_data !== 16'hA5A5) begin
            tests_failed++;
            $display("[TB] FAIL after_collision: got %h/%h expected a5a5/a5a5", ra_data, rb_data);
        end
    endtask

    task automatic test_imm();
        rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        rsv_en = 1'b0;
        rd_en = 1'b1; imm_sel = 1'b1; imm = 16'h00FF; ra_addr = 5'd3; rb_addr = 5'd3;
        tick();
        rd_en = 1'b0; imm_sel = 1'b0;
        tests_run++;
        if (ra_data !== 16'h00FF || ra_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL imm_port_a: got %h/%b expected 00ff/0", ra_data, ra_busy);
        end
        tests_run++;
        if (rb_data !== 16'hBEEF || rb_busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL imm_port_b: got %h/%b expected beef/1", rb_data, rb_busy);
        end
        wr_en = 1'b1; wc_addr = 5'd3; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_scoreboard();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        rsv_en = 1'b0;
        rd_en = 1'b1; ra_addr = 5'd3; rb_addr = 5'd9;
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (rb_busy !== 1'b1 || ra_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reserve_seen: got ra=%b rb=%b expected ra=0 rb=1", ra_busy, rb_busy);
        end
        rsv_en = 1'b1; rsv_addr = 5'd10; rd_en = 1'b1; rb_addr = 5'd10;
        tick();
        rsv_en = 1'b0;
        tests_run++;
        if (rb_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reserve_read_same_cycle: got %b expected 0", rb_busy);
        end
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (rb_busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reserve_next_read: got %b expected 1", rb_busy);
        end
        wr_en = 1'b1; wc_addr = 5'd9; wr_data = 16'h0909; rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        rd_en = 1'b1; rb_addr = 5'd9;
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (rb_busy !== 1'b1 || rb_data !== 16'h0909) begin
            tests_failed++;
            $display("[TB] FAIL set_beats_clear: got %h/%b expected 0909/1", rb_data, rb_busy);
        end
        wr_en = 1'b1; wc_addr = 5'd9; wr_data = 16'h9999;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1; rb_addr = 5'd9;
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (rb_busy !== 1'b0 || rb_data !== 16'h9999) begin
            tests_failed++;
            $display("[TB] FAIL writeback_release: got %h/%b expected 9999/0", rb_data, rb_busy);
        end
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        rsv_en = 1'b0;
        rd_en = 1'b1; ra_addr = 5'd0; rb_addr = 5'd0;
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (ra_busy !== 1'b0 || rb_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL zero_never_busy: got %b/%b expected 0/0", ra_busy, rb_busy);
        end
    endtask

    task automatic test_reset_override();
        wr_en = 1'b1; wc_addr = 5'd4; wr_data = 16'h4444; rsv_en = 1'b1; rsv_addr = 5'd4;
        tick();
        rst = 1'b1; rd_en = 1'b1; ra_addr = 5'd4; rb_addr = 5'd4;
        wr_data = 16'h5555;
        tick();
        rst = 1'b0; wr_en = 1'b0; rsv_en = 1'b0; rd_en = 1'b0;
        tests_run++;
        if ({ra_data, rb_data} !== 32'h0 || {ra_busy, rb_busy, rd_valid} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_override_outputs: got %h %h %b expected 0 0 000", ra_data, rb_data, {ra_busy, rb_busy, rd_valid});
        end
        rd_en = 1'b1; ra_addr = 5'd4; rb_addr = 5'd7;
        tick();
        rd_en = 1'b0;
        tests_run++;
        if (ra_data !== 16'h0000 || ra_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_clears_r4: got %h/%b expected 0000/0", ra_data, ra_busy);
        end
        tests_run++;
        if (rb_data !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_clears_r7: got %h expected 0000", rb_data);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_collision();
        test_imm();
        test_scoreboard();
        test_reset_override();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
